seven_seg_scan_decoder: RTL and testbench
=========================================

Name: seven_seg_scan_decoder

Overview:
- Receive-side counterpart of the clock's multiplexed 7-segment display output.
- Samples the scanned digit_sel/seg_out bus, decodes each segment pattern back to BCD, and assembles complete HH:MM:SS frames.
- Used as an on-chip display readback/self-check monitor and as a bench checker for the display path.

Parameters:
- SEL_ACTIVE_LOW, 1, digit_sel polarity: 1 = selected digit driven 0.
- SEG_ACTIVE_LOW, 1, seg_out polarity: 1 = lit segment driven 0.
- STABLE_CYCLES, 4, consecutive identical samples required to accept a digit (minimum 1).
- TIMEOUT_CYCLES, 65535, cycles without a completed frame before stale asserts.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- digit_sel  in  6  scan select; bit5 = hour tens, down to bit0 = second units
- seg_out  in  7  segment bus {g,f,e,d,c,b,a}
- hour_bcd  out  8  {tens,units} of the last complete frame
- min_bcd  out  8  as above, minutes
- sec_bcd  out  8  as above, seconds
- frame_valid  out  1  one-cycle pulse when a frame is published
- frame_err  out  1  qualifies frame_valid: frame held an undecodable or out-of-range digit
- stale  out  1  level; no frame completed within TIMEOUT_CYCLES
- frame_count  out  8  published-frame counter, wraps 255→0

Behaviour:
- Reset values: all outputs 0, seen-mask 0, digit store 0, stability and timeout counters 0.
- Stage 1 registers digit_sel and seg_out, then normalises both to active-high.
- Select qualification: the sample is used only if the normalised select is exactly one-hot. Zero or multiple bits set clears the stability counter and leaves the accept flag clear.
- Stability:
  - Counter increments while the registered pair equals the previous registered pair.
  - Any change reloads the counter to 1 and clears the accept flag.
  - When the counter reaches STABLE_CYCLES and the accept flag is clear: capture the digit, then set the accept flag. This gives exactly one capture per dwell.
- Capture:
  - Decode the pattern via the table 0–9. Table, active-high: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - Any other pattern, including blank, stores 4'hF and sets the frame error accumulator.
  - Range check sets the error accumulator if hour tens >2, minute tens >5, or second tens >5.
  - The selected slot is overwritten (latest value wins) and its seen-mask bit is set.
- Publish:
  - Occurs in the cycle after the capture that makes the seen-mask 6'b111111.
  - Outputs updated from the store; frame_valid=1 for one cycle; frame_err = accumulator; frame_count +1.
  - Seen-mask and accumulator clear in the same cycle.
  - A capture in the publish cycle belongs to the next frame.
- Latency: pair stable at the pin from cycle t → capture at t+STABLE_CYCLES → frame_valid at t+STABLE_CYCLES+1 for the completing digit.
- Timeout:
  - Counter clears on publish and otherwise increments, saturating at TIMEOUT_CYCLES.
  - stale = (counter == TIMEOUT_CYCLES). stale deasserts in the publish cycle.
- Outputs hold their values between publishes; stale does not alter the BCD outputs.
- Reset mid-frame: everything returns to reset values immediately (asynchronous). A partial frame is discarded.
- Wrap: frame_count 255 + publish → 0, no flag.

Decomposition:
- Shared package:
  - Segment pattern constants SEG_0..SEG_9.
  - Digit index constants DIG_HT, DIG_HU, DIG_MT, DIG_MU, DIG_ST, DIG_SU (5..0).
  - The segment bit-order definition.
  - Error code 4'hF.
  - Shared with the existing 7-segment encoder so both ends use one table.
- Sub-module: seg7_pattern_decoder, combinational: 7-bit active-high pattern → 4-bit BCD plus valid bit.
- Stability filter, frame assembler and timeout stay in the top block.

Test Plan:
- Reset then scan 02:03:00 (active-low, 8 cycles/digit, order bit5→bit0, two rounds) → first frame_valid with hour_bcd=8'h02, min_bcd=8'h03, sec_bcd=8'h00, frame_err=0, frame_count=1; second round gives frame_count=2.
- Dwell of 3 cycles per digit with STABLE_CYCLES=4 → no capture, no frame_valid, stale=1 after TIMEOUT_CYCLES (use TIMEOUT_CYCLES=200 in bench).
- One round with second-units pattern 1111111 (blank, active-low) → frame_valid with sec_bcd[3:0]=4'hF, frame_err=1. A following clean round → frame_err=0.
- Glitches: 1-cycle digit_sel=6'b000000 and 6'b001100 inserted between digits → ignored; frame equals the glitch-free reference 12:59:59.
- Hour tens shows 3 (33:00:00) → frame_err=1, hour_bcd=8'h33.
- Assert rst for 1 cycle after 4 digits captured, then one full round of 23:45:01 → single frame_valid, values 8'h23/8'h45/8'h01, frame_count=1; push 256 frames → frame_count wraps to 0.

Source files
------------

// File: rtl/seven_seg_scan_decoder_pkg.sv
// Shared 7-segment definitions: segment bit order, digit pattern table and digit slot indices.
// The scan encoder and this readback decoder both import it, so both ends use one table.
package seven_seg_scan_decoder_pkg;

    // Segment bus bit order, MSB first: {g,f,e,d,c,b,a}.
    typedef struct packed {
        logic g;
        logic f;
        logic e;
        logic d;
        logic c;
        logic b;
        logic a;
    } seg_bits_t;

    typedef logic [6:0] seg_pattern_t;
    typedef logic [3:0] bcd_t;

    // Active-high patterns; a lit segment is a 1.
    localparam seg_pattern_t SEG_0 = 7'b0111111;
    localparam seg_pattern_t SEG_1 = 7'b0000110;
    localparam seg_pattern_t SEG_2 = 7'b1011011;
    localparam seg_pattern_t SEG_3 = 7'b1001111;
    localparam seg_pattern_t SEG_4 = 7'b1100110;
    localparam seg_pattern_t SEG_5 = 7'b1101101;
    localparam seg_pattern_t SEG_6 = 7'b1111101;
    localparam seg_pattern_t SEG_7 = 7'b0000111;
    localparam seg_pattern_t SEG_8 = 7'b1111111;
    localparam seg_pattern_t SEG_9 = 7'b1101111;

    // Position of each display digit on the scan select bus.
    localparam int DIG_HT = 5;
    localparam int DIG_HU = 4;
    localparam int DIG_MT = 3;
    localparam int DIG_MU = 2;
    localparam int DIG_ST = 1;
    localparam int DIG_SU = 0;

    localparam bcd_t BCD_ERR = 4'hF;

    function automatic seg_pattern_t seg7_encode(input bcd_t value);
        seg_pattern_t pattern;
        case (value)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = '0;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seven_seg_scan_decoder_seg7_pattern_decoder.sv
// Combinational inverse of the 7-segment table: active-high pattern to BCD digit.
// Anything outside the ten legal glyphs (including blank) reports invalid with the error code.
module seg7_pattern_decoder
    import seven_seg_scan_decoder_pkg::*;
(
    input  seg_pattern_t pattern,
    output bcd_t         bcd,
    output logic         valid
);

    always_comb begin
        valid = 1'b1;
        bcd   = BCD_ERR;
        case (pattern)
            SEG_0:   bcd = 4'd0;
            SEG_1:   bcd = 4'd1;
            SEG_2:   bcd = 4'd2;
            SEG_3:   bcd = 4'd3;
            SEG_4:   bcd = 4'd4;
            SEG_5:   bcd = 4'd5;
            SEG_6:   bcd = 4'd6;
            SEG_7:   bcd = 4'd7;
            SEG_8:   bcd = 4'd8;
            SEG_9:   bcd = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Readback monitor for the multiplexed HH:MM:SS display bus: filters the scan, decodes
// each stable digit back to BCD and publishes complete frames with error and staleness status.
module seven_seg_scan_decoder
    import seven_seg_scan_decoder_pkg::*;
#(
    parameter int SEL_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] digit_sel,
    input  logic [6:0] seg_out,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       stale,
    output logic [7:0] frame_count
);

    localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);
    localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT_CYCLES);
    localparam logic [5:0]        SEEN_ALL = 6'b111111;

    logic [5:0]        sel_q, sel_d, prev_sel_q, prev_sel_d;
    logic [6:0]        seg_q, seg_d, prev_seg_q, prev_seg_d;
    logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
    logic              accept_q, accept_d;
    logic [5:0][3:0]   digit_q, digit_d;
    logic [5:0]        seen_q, seen_d;
    logic              err_acc_q, err_acc_d;
    logic [7:0]        hour_bcd_q, hour_bcd_d;
    logic [7:0]        min_bcd_q, min_bcd_d;
    logic [7:0]        sec_bcd_q, sec_bcd_d;
    logic              frame_valid_q, frame_valid_d;
    logic              frame_err_q, frame_err_d;
    logic [7:0]        frame_count_q, frame_count_d;
    logic [TO_W-1:0]   timeout_q, timeout_d;

    logic [5:0]   sel_norm;
    seg_pattern_t seg_norm;
    logic [2:0]   sel_idx;
    bcd_t         dec_bcd;
    logic         dec_valid;
    logic         sel_onehot;
    logic         pair_same;
    logic         capture;
    logic         publish;
    logic         range_err;

    assign sel_norm = sel_q ^ {6{SEL_ACTIVE_LOW != 0}};
    assign seg_norm = seg_q ^ {7{SEG_ACTIVE_LOW != 0}};

    seg7_pattern_decoder u_decoder (
        .pattern (seg_norm),
        .bcd     (dec_bcd),
        .valid   (dec_valid)
    );

    always_comb begin
        sel_idx = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (sel_norm[i]) begin
                sel_idx = 3'(i);
            end
        end
    end

    always_comb begin
        sel_d      = digit_sel;
        seg_d      = seg_out;
        prev_sel_d = sel_q;
        prev_seg_d = seg_q;

        sel_onehot = $onehot(sel_norm);
        pair_same  = (sel_q == prev_sel_q) && (seg_q == prev_seg_q);
        publish    = (seen_q == SEEN_ALL);

        // The accept flag limits each dwell to a single capture however long it lasts.
        stab_cnt_d = stab_cnt_q;
        accept_d   = accept_q;
        if (!sel_onehot) begin
            stab_cnt_d = '0;
            accept_d   = 1'b0;
        end else if (!pair_same) begin
            stab_cnt_d = STAB_W'(1);
            accept_d   = 1'b0;
        end else if (stab_cnt_q != STAB_MAX) begin
            stab_cnt_d = stab_cnt_q + STAB_W'(1);
        end
        capture = sel_onehot && (stab_cnt_d == STAB_MAX) && !accept_d;
        if (capture) begin
            accept_d = 1'b1;
        end

        range_err = 1'b0;
        if (dec_valid) begin
            if (sel_idx == 3'(DIG_HT) && dec_bcd > 4'd2) range_err = 1'b1;
            if (sel_idx == 3'(DIG_MT) && dec_bcd > 4'd5) range_err = 1'b1;
            if (sel_idx == 3'(DIG_ST) && dec_bcd > 4'd5) range_err = 1'b1;
        end

        // A capture landing in the publish cycle starts the next frame's bookkeeping.
        digit_d   = digit_q;
        seen_d    = publish ? 6'b000000 : seen_q;
        err_acc_d = publish ? 1'b0 : err_acc_q;
        if (capture) begin
            digit_d[sel_idx] = dec_valid ? dec_bcd : BCD_ERR;
            seen_d[sel_idx]  = 1'b1;
            err_acc_d        = err_acc_d | !dec_valid | range_err;
        end

        hour_bcd_d    = hour_bcd_q;
        min_bcd_d     = min_bcd_q;
        sec_bcd_d     = sec_bcd_q;
        frame_err_d   = frame_err_q;
        frame_count_d = frame_count_q;
        frame_valid_d = publish;
        if (publish) begin
            hour_bcd_d    = {digit_q[DIG_HT], digit_q[DIG_HU]};
            min_bcd_d     = {digit_q[DIG_MT], digit_q[DIG_MU]};
            sec_bcd_d     = {digit_q[DIG_ST], digit_q[DIG_SU]};
            frame_err_d   = err_acc_q;
            frame_count_d = frame_count_q + 8'd1;
        end

        timeout_d = timeout_q;
        if (publish) begin
            timeout_d = '0;
        end else if (timeout_q != TO_MAX) begin
            timeout_d = timeout_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q         <= '0;
            seg_q         <= '0;
            prev_sel_q    <= '0;
            prev_seg_q    <= '0;
            stab_cnt_q    <= '0;
            accept_q      <= 1'b0;
            digit_q       <= '0;
            seen_q        <= '0;
            err_acc_q     <= 1'b0;
            hour_bcd_q    <= '0;
            min_bcd_q     <= '0;
            sec_bcd_q     <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_count_q <= '0;
            timeout_q     <= '0;
        end else begin
            sel_q         <= sel_d;
            seg_q         <= seg_d;
            prev_sel_q    <= prev_sel_d;
            prev_seg_q    <= prev_seg_d;
            stab_cnt_q    <= stab_cnt_d;
            accept_q      <= accept_d;
            digit_q       <= digit_d;
            seen_q        <= seen_d;
            err_acc_q     <= err_acc_d;
            hour_bcd_q    <= hour_bcd_d;
            min_bcd_q     <= min_bcd_d;
            sec_bcd_q     <= sec_bcd_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            frame_count_q <= frame_count_d;
            timeout_q     <= timeout_d;
        end
    end

    assign hour_bcd    = hour_bcd_q;
    assign min_bcd     = min_bcd_q;
    assign sec_bcd     = sec_bcd_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign frame_count = frame_count_q;
    assign stale       = (timeout_q == TO_MAX);

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Self-checking bench: scans HH:MM:SS frames onto an active-low display bus and compares
// every published frame against a digit-level reference model.
module tb_seven_seg_scan_decoder;

    localparam int STABLE  = 4;
    localparam int TIMEOUT = 200;

    typedef struct packed {
        logic [7:0] h;
        logic [7:0] m;
        logic [7:0] s;
        logic       err;
        logic [7:0] cnt;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] digit_sel = 6'h3F;
    logic [6:0] seg_out = 7'h7F;
    logic [7:0] hour_bcd, min_bcd, sec_bcd, frame_count;
    logic       frame_valid, frame_err, stale;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_count = 8'd0;
    frame_t     fq[$];

    seven_seg_scan_decoder #(
        .SEL_ACTIVE_LOW (1),
        .SEG_ACTIVE_LOW (1),
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .digit_sel   (digit_sel),
        .seg_out     (seg_out),
        .hour_bcd    (hour_bcd),
        .min_bcd     (min_bcd),
        .sec_bcd     (sec_bcd),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .stale       (stale),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    // Every published frame is recorded just after the edge that produced it.
    always @(posedge clk) begin
        #1;
        if (frame_valid) begin
            fq.push_back('{h: hour_bcd, m: min_bcd, s: sec_bcd, err: frame_err, cnt: frame_count});
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running at 1000000 ns, expected to finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    // Reference: digits are HHMMSS nibbles; any nibble above 9 is shown blank.
    function automatic frame_t expect_frame(input logic [23:0] digits, input logic [7:0] cnt);
        frame_t     e;
        logic [3:0] n [6];
        logic [3:0] raw;
        logic       err;
        err = 1'b0;
        for (int i = 0; i < 6; i++) begin
            raw = digits[i*4 +: 4];
            if (raw > 4'd9) begin
                n[i] = 4'hF;
                err  = 1'b1;
            end else begin
                n[i] = raw;
            end
        end
        if (n[5] <= 4'd9 && n[5] > 4'd2) err = 1'b1;
        if (n[3] <= 4'd9 && n[3] > 4'd5) err = 1'b1;
        if (n[1] <= 4'd9 && n[1] > 4'd5) err = 1'b1;
        e.h   = {n[5], n[4]};
        e.m   = {n[3], n[2]};
        e.s   = {n[1], n[0]};
        e.err = err;
        e.cnt = cnt;
        return e;
    endfunction

    function automatic logic [23:0] rand_digits();
        logic [23:0] d;
        d = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 9)),
             4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
             4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        if ($urandom_range(0, 7) == 0) begin
            d[4*$urandom_range(0, 5) +: 4] = 4'hF;
        end
        return d;
    endfunction

    task automatic go_idle();
        digit_sel = 6'h3F;
        seg_out   = 7'h7F;
    endtask

    task automatic drive_digit(input int idx, input logic [3:0] val, input int dwell);
        digit_sel = ~(6'b000001 << idx);
        seg_out   = ~glyph(val);
        repeat (dwell) @(negedge clk);
    endtask

    task automatic scan_round(input logic [23:0] digits, input int dwell_lo, input int dwell_hi,
                              input bit glitch);
        for (int idx = 5; idx >= 0; idx--) begin
            if (glitch && idx != 5) begin
                digit_sel = (idx % 2 == 1) ? 6'b000000 : 6'b001100;
                @(negedge clk);
            end
            drive_digit(idx, digits[idx*4 +: 4], int'($urandom_range(dwell_lo, dwell_hi)));
        end
        go_idle();
    endtask

    task automatic wait_frame(input int budget, output bit got);
        for (int i = 0; i < budget && fq.size() == 0; i++) @(negedge clk);
        got = (fq.size() != 0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        go_idle();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({hour_bcd, min_bcd, sec_bcd, frame_count} !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_bcd: got %h expected 00000000", {hour_bcd, min_bcd, sec_bcd, frame_count});
        end
        n_checks++;
        if ({frame_valid, frame_err, stale} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: got valid/err/stale=%b expected 000", {frame_valid, frame_err, stale});
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({frame_valid, stale} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL after_reset_flags: got valid/stale=%b expected 00", {frame_valid, stale});
        end
        exp_count = 8'd0;
    endtask

    task automatic test_two_rounds();
        frame_t f, e;
        bit     got;
        for (int r = 0; r < 2; r++) begin
            scan_round(24'h020300, 8, 8, 1'b0);
            wait_frame(20, got);
            exp_count = exp_count + 8'd1;
            e = expect_frame(24'h020300, exp_count);
            n_checks++;
            if (!got) begin
                n_fail++;
                $display("[TB] FAIL two_rounds_%0d: got no frame_valid, expected frame %h", r, e);
            end else begin
                f = fq.pop_front();
                if (f !== e) begin
                    n_fail++;
                    $display("[TB] FAIL two_rounds_%0d: got %h expected %h", r, f, e);
                end
            end
        end
    endtask

    task automatic test_short_dwell();
        for (int c = 0; c < 80; c++) begin
            drive_digit(5 - (c % 6), 4'd8, STABLE - 1);
            if (c == 20) begin
                n_checks++;
                if (stale !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL short_dwell_early_stale: got %b expected 0", stale);
                end
            end
        end
        go_idle();
        @(negedge clk);
        n_checks++;
        if (stale !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL short_dwell_stale: got %b expected 1", stale);
        end
        n_checks++;
        if (fq.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL short_dwell_frames: got %0d frames expected 0", fq.size());
            fq.delete();
        end
        n_checks++;
        if ({hour_bcd, min_bcd, sec_bcd} !== 24'h020300) begin
            n_fail++;
            $display("[TB] FAIL short_dwell_hold: got %h expected 020300", {hour_bcd, min_bcd, sec_bcd});
        end
    endtask

    task automatic test_blank_digit();
        frame_t f, e;
        bit     got;
        logic [23:0] rounds [2];
        rounds[0] = 24'h12345F;
        rounds[1] = 24'h123456;
        for (int r = 0; r < 2; r++) begin
            scan_round(rounds[r], 6, 6, 1'b0);
            wait_frame(20, got);
            exp_count = exp_count + 8'd1;
            e = expect_frame(rounds[r], exp_count);
            n_checks++;
            if (!got) begin
                n_fail++;
                $display("[TB] FAIL blank_round_%0d: got no frame_valid, expected frame %h", r, e);
            end else begin
                f = fq.pop_front();
                if (f !== e) begin
                    n_fail++;
                    $display("[TB] FAIL blank_round_%0d: got %h expected %h", r, f, e);
                end
            end
            n_checks++;
            if (stale !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL blank_round_%0d_stale: got %b expected 0", r, stale);
            end
        end
    endtask

    task automatic test_glitch_and_range();
        frame_t f, e;
        bit     got;
        logic [23:0] rounds [2];
        rounds[0] = 24'h125959;
        rounds[1] = 24'h330000;
        for (int r = 0; r < 2; r++) begin
            scan_round(rounds[r], 5, 7, r == 0);
            wait_frame(20, got);
            exp_count = exp_count + 8'd1;
            e = expect_frame(rounds[r], exp_count);
            n_checks++;
            if (!got) begin
                n_fail++;
                $display("[TB] FAIL glitch_range_%0d: got no frame_valid, expected frame %h", r, e);
            end else begin
                f = fq.pop_front();
                if (f !== e) begin
                    n_fail++;
                    $display("[TB] FAIL glitch_range_%0d: got %h expected %h", r, f, e);
                end
            end
        end
    endtask

    task automatic test_latency();
        frame_t f, e;
        logic [23:0] d;
        int first;
        d = rand_digits();
        for (int idx = 5; idx >= 1; idx--) drive_digit(idx, d[idx*4 +: 4], 8);
        digit_sel = ~6'b000001;
        seg_out   = ~glyph(d[3:0]);
        first = 0;
        // The first sampling edge after this drive is "cycle t"; that edge's falling edge is k=1.
        for (int k = 1; k <= 20 && first == 0; k++) begin
            @(negedge clk);
            if (frame_valid) first = k;
        end
        go_idle();
        @(negedge clk);
        exp_count = exp_count + 8'd1;
        e = expect_frame(d, exp_count);
        n_checks++;
        if (first != STABLE + 2) begin
            n_fail++;
            $display("[TB] FAIL latency: got frame_valid at k=%0d expected k=%0d", first, STABLE + 2);
        end
        n_checks++;
        if (fq.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL latency_frame: got no frame, expected %h", e);
        end else begin
            f = fq.pop_front();
            if (f !== e) begin
                n_fail++;
                $display("[TB] FAIL latency_frame: got %h expected %h", f, e);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        frame_t f, e;
        bit     got;
        for (int idx = 5; idx >= 2; idx--) drive_digit(idx, (idx == 5) ? 4'hF : 4'd9, 8);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({frame_count, hour_bcd, min_bcd, sec_bcd} !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_async: got %h expected 00000000", {frame_count, hour_bcd, min_bcd, sec_bcd});
        end
        go_idle();
        @(negedge clk);
        rst = 1'b1;
        fq.delete();
        exp_count = 8'd0;
        @(negedge clk);
        scan_round(24'h234501, 8, 8, 1'b0);
        wait_frame(20, got);
        exp_count = exp_count + 8'd1;
        e = expect_frame(24'h234501, exp_count);
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_frame: got no frame_valid, expected frame %h", e);
        end else begin
            f = fq.pop_front();
            if (f !== e) begin
                n_fail++;
                $display("[TB] FAIL mid_reset_frame: got %h expected %h", f, e);
            end
        end
        repeat (30) @(negedge clk);
        n_checks++;
        if (fq.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_single: got %0d extra frames expected 0", fq.size());
            fq.delete();
        end
    endtask

    task automatic test_wrap_random();
        frame_t f, e;
        bit     got;
        logic [23:0] d;
        for (int r = 0; r < 255; r++) begin
            d = rand_digits();
            scan_round(d, STABLE, STABLE + 3, $urandom_range(0, 1) == 1);
            wait_frame(20, got);
            exp_count = exp_count + 8'd1;
            e = expect_frame(d, exp_count);
            n_checks++;
            if (!got) begin
                n_fail++;
                $display("[TB] FAIL random_frame_%0d: got no frame_valid, expected frame %h", r, e);
            end else begin
                f = fq.pop_front();
                if (f !== e) begin
                    n_fail++;
                    $display("[TB] FAIL random_frame_%0d: got %h expected %h", r, f, e);
                end
            end
        end
        n_checks++;
        if (frame_count !== 8'd0) begin
            n_fail++;
            $display("[TB] FAIL wrap_count: got %0d expected 0", frame_count);
        end
    endtask

    initial begin
        test_reset();
        test_two_rounds();
        test_short_dwell();
        test_blank_digit();
        test_glitch_and_range();
        test_latency();
        test_reset_mid_frame();
        test_wrap_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
